axi4_wch_drop_ctrl: RTL



---
 rtl/axi_rab_pkg.sv | 24 ++
 rtl/axi4_wch_drop_ctrl_if.sv | 30 +++
 rtl/axi_buffer_rab.sv | 66 ++++++
 rtl/axi4_wch_drop_ctrl.sv | 124 ++++++++++++
 4 files changed

// File: rtl/axi_rab_pkg.sv
// Shared RAB types: W-channel drop sequencer state and decision-entry layout.
package axi_rab_pkg;

    // The decision struct carries an ID as wide as the RAB slave-port AXI ID.
    localparam int unsigned RAB_ID_WIDTH = 10;

    typedef enum logic [1:0] {
        StIdle,
        StFwd,
        StDropReq,
        StDrop
    } wdrop_state_t;

    typedef struct packed {
        logic                    drop;
        logic [RAB_ID_WIDTH-1:0] id;
    } wdrop_entry_t;

    // State a burst starts in once its decision reaches the head.
    function automatic wdrop_state_t wdrop_entry_state(input logic drop);
        return drop ? StDropReq : StFwd;
    endfunction

endpackage

// File: rtl/axi4_wch_drop_ctrl_if.sv
// AXI4 write-data channel bundle; master drives payload/valid, slave drives ready.
interface axi4_wch_drop_ctrl_if #(
    parameter int unsigned C_AXI_DATA_WIDTH = 64,
    parameter int unsigned C_AXI_USER_WIDTH = 4
);
    logic [C_AXI_DATA_WIDTH-1:0]   wdata;
    logic [C_AXI_DATA_WIDTH/8-1:0] wstrb;
    logic [C_AXI_USER_WIDTH-1:0]   wuser;
    logic                          wlast;
    logic                          wvalid;
    logic                          wready;

    modport master (
        output wdata,
        output wstrb,
        output wuser,
        output wlast,
        output wvalid,
        input  wready
    );

    modport slave (
        input  wdata,
        input  wstrb,
        input  wuser,
        input  wlast,
        input  wvalid,
        output wready
    );
endinterface

// File: rtl/axi_buffer_rab.sv
// Small synchronous FIFO used for RAB side queues. Besides the head entry it
// exposes the entry directly behind the head so a consumer can pre-decide
// what follows the current pop without a bubble.
module axi_buffer_rab #(
    parameter int unsigned DATA_WIDTH = 11,
    parameter int unsigned DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  valid_in,
    output logic                  ready_out,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  valid_out,
    input  logic                  ready_in,
    output logic [DATA_WIDTH-1:0] data_next_out,
    output logic                  valid_next_out
);
    localparam int unsigned AddrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned PtrW  = AddrW + 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PtrW-1:0]       wr_ptr;
    logic [PtrW-1:0]       rd_ptr;
    logic [PtrW-1:0]       level;
    logic [AddrW-1:0]      rd_idx;
    logic [AddrW-1:0]      rd_next_idx;
    logic                  full;
    logic                  push;
    logic                  pop;

    // Occupancy and handshake decode; a full FIFO refuses pushes even on a pop cycle.
    always_comb begin
        level          = wr_ptr - rd_ptr;
        full           = (level == PtrW'(DEPTH));
        ready_out      = !full;
        valid_out      = (level != '0);
        valid_next_out = (level >= PtrW'(2));
        push           = valid_in && !full;
        pop            = ready_in && valid_out;
        rd_idx         = rd_ptr[AddrW-1:0];
        rd_next_idx    = rd_idx + AddrW'(1);
        data_out       = mem[rd_idx];
        data_next_out  = mem[rd_next_idx];
    end

    // Pointer and storage update.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wr_ptr[AddrW-1:0]] <= data_in;
                wr_ptr                 <= wr_ptr + PtrW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PtrW'(1);
            end
        end
    end

endmodule

// File: rtl/axi4_wch_drop_ctrl.sv
// W-channel sequencer: follows the AW forward/drop decisions in order, passes
// forwarded bursts to the master port and swallows dropped ones, handing the
// dropped burst's ID and end-of-burst event to the B-channel sender.
module axi4_wch_drop_ctrl
    import axi_rab_pkg::*;
#(
    parameter int unsigned C_AXI_ID_WIDTH   = RAB_ID_WIDTH,
    parameter int unsigned C_AXI_DATA_WIDTH = 64,
    parameter int unsigned C_AXI_USER_WIDTH = 4,
    parameter int unsigned DEPTH            = 4
) (
    input  logic                      axi4_aclk,
    input  logic                      axi4_arstn,
    input  logic                      aw_dec_valid,
    input  logic                      aw_dec_drop,
    input  logic [C_AXI_ID_WIDTH-1:0] aw_dec_id,
    output logic                      aw_dec_ready,
    axi4_wch_drop_ctrl_if.slave       s_axi4,
    axi4_wch_drop_ctrl_if.master      m_axi4,
    output logic                      trans_drop,
    output logic [C_AXI_ID_WIDTH-1:0] trans_id,
    input  logic                      trans_drop_ready,
    output logic                      wlast_received,
    output logic [15:0]               drop_cnt
);
    localparam int unsigned EntryWidth = C_AXI_ID_WIDTH + 1;

    logic [EntryWidth-1:0] dec_word;
    logic [EntryWidth-1:0] head_word;
    logic [EntryWidth-1:0] next_word;
    logic                  head_valid;
    logic                  next_valid;
    logic                  fifo_pop;
    wdrop_entry_t          load_entry;
    logic                  load_valid;
    logic                  take_next;
    logic                  fwd_last_hs;
    logic                  drop_last_hs;
    wdrop_state_t          state;

    assign dec_word = {aw_dec_drop, aw_dec_id};

    axi_buffer_rab #(
        .DATA_WIDTH (EntryWidth),
        .DEPTH      (DEPTH)
    ) i_dec_fifo (
        .clk            (axi4_aclk),
        .rstn           (axi4_arstn),
        .data_in        (dec_word),
        .valid_in       (aw_dec_valid),
        .ready_out      (aw_dec_ready),
        .data_out       (head_word),
        .valid_out      (head_valid),
        .ready_in       (fifo_pop),
        .data_next_out  (next_word),
        .valid_next_out (next_valid)
    );

    // Payload always follows the slave side so it is never X, even when not valid.
    assign m_axi4.wdata = C_AXI_DATA_WIDTH'(s_axi4.wdata);
    assign m_axi4.wstrb = (C_AXI_DATA_WIDTH/8)'(s_axi4.wstrb);
    assign m_axi4.wuser = C_AXI_USER_WIDTH'(s_axi4.wuser);
    assign m_axi4.wlast = s_axi4.wlast;

    // Handshake routing per state and burst-end detection.
    always_comb begin
        m_axi4.wvalid = 1'b0;
        s_axi4.wready = 1'b0;
        unique case (state)
            StFwd: begin
                m_axi4.wvalid = s_axi4.wvalid;
                s_axi4.wready = m_axi4.wready;
            end
            StDrop: begin
                s_axi4.wready = 1'b1;
            end
            default: begin
            end
        endcase
        fwd_last_hs  = (state == StFwd) && s_axi4.wvalid && m_axi4.wready && s_axi4.wlast;
        drop_last_hs = (state == StDrop) && s_axi4.wvalid && s_axi4.wlast;
        fifo_pop     = fwd_last_hs || drop_last_hs;
    end

    // Which decision to start next: the head when idle, else the entry behind
    // the head that is being popped this cycle.
    always_comb begin
        take_next  = (state == StIdle) || fifo_pop;
        load_entry = (state == StIdle) ? wdrop_entry_t'(head_word) : wdrop_entry_t'(next_word);
        load_valid = (state == StIdle) ? head_valid : next_valid;
    end

    // Sequencer FSM with registered drop request, end-of-drop pulse and counter.
    always_ff @(posedge axi4_aclk or negedge axi4_arstn) begin
        if (!axi4_arstn) begin
            state          <= StIdle;
            trans_drop     <= 1'b0;
            trans_id       <= '0;
            wlast_received <= 1'b0;
            drop_cnt       <= '0;
        end else begin
            wlast_received <= drop_last_hs;
            if (drop_last_hs) begin
                drop_cnt <= drop_cnt + 16'd1;
            end
            if (take_next) begin
                if (load_valid) begin
                    state      <= wdrop_entry_state(load_entry.drop);
                    trans_drop <= load_entry.drop;
                    if (load_entry.drop) begin
                        trans_id <= load_entry.id;
                    end
                end else begin
                    state      <= StIdle;
                    trans_drop <= 1'b0;
                end
            end else if ((state == StDropReq) && trans_drop_ready) begin
                state      <= StDrop;
                trans_drop <= 1'b0;
            end
        end
    end

endmodule
